// File: rtl/shift_sub_div_pkg.sv
// Shared definitions for the iterative shift-subtract divider: FSM state
// encodings, cycle-count helper and two's-complement sign helpers.
package shift_sub_div_pkg;

  // Widest operand the sign helpers handle. Callers zero-extend into this
  // width and cast the result back down to their own width.
  localparam int MAX_WIDTH = 64;

  localparam logic [MAX_WIDTH-1:0] ONE = {{(MAX_WIDTH-1){1'b0}}, 1'b1};

  // FSM state encodings.
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t CALC = 2'd1;
  localparam state_t DONE = 2'd2;

  // Number of CALC cycles needed to resolve all quotient bits.
  function automatic int num_cycles(input int width, input int parallel_ops);
    return width / parallel_ops;
  endfunction

  // Two's-complement negation. The low bits of the result do not depend on
  // the high bits of the input, so truncating the result afterwards is safe.
  function automatic logic [MAX_WIDTH-1:0] negate(input logic [MAX_WIDTH-1:0] value);
    return ~value + ONE;
  endfunction

  // Negate only when asked. Used both for magnitude and for sign fixup.
  function automatic logic [MAX_WIDTH-1:0] cond_negate(input logic [MAX_WIDTH-1:0] value,
                                                       input logic                 neg);
    return neg ? negate(value) : value;
  endfunction

  // Magnitude of a value whose sign bit is supplied separately. The most
  // negative value maps onto itself, which is the correct unsigned magnitude.
  function automatic logic [MAX_WIDTH-1:0] abs_value(input logic [MAX_WIDTH-1:0] value,
                                                     input logic                 is_neg);
    return cond_negate(value, is_neg);
  endfunction

endpackage

// File: rtl/div_step_chain.sv
// Combinational chain of restoring division steps. Each step shifts the
// partial remainder left, pulls in one dividend bit (MSB first) and keeps the
// trial subtraction only when it does not go negative.
module div_step_chain #(
  parameter int WIDTH        = 16,
  parameter int PARALLEL_OPS = 4
) (
  input  logic [WIDTH-1:0]        rem_in,
  input  logic [PARALLEL_OPS-1:0] dividend_bits,
  input  logic [WIDTH-1:0]        divisor,
  output logic [WIDTH-1:0]        rem_out,
  output logic [PARALLEL_OPS-1:0] quotient_bits
);

  // Ripple PARALLEL_OPS restoring steps; dividend_bits[PARALLEL_OPS-1] goes first.
  always_comb begin
    logic [WIDTH:0] partial;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    partial       = {1'b0, rem_in};
    shifted       = '0;
    trial         = '0;
    quotient_bits = '0;
    for (int i = PARALLEL_OPS - 1; i >= 0; i--) begin
      // NOTE: blocking assignments here on purpose: each step must see the
      // remainder produced by the previous step within the same cycle.
      // The partial remainder is always below the divisor, so its top bit is
      // zero and WIDTH+1 bits hold the shifted value without loss.
      shifted          = {partial[WIDTH-1:0], dividend_bits[i]};
      trial            = shifted - {1'b0, divisor};
      quotient_bits[i] = ~trial[WIDTH];
      partial          = trial[WIDTH] ? shifted : trial;
    end
    rem_out = partial[WIDTH-1:0];
  end

endmodule

// File: rtl/shift_sub_divider.sv
// Iterative restoring shift-subtract divider with the start/valid_in,
// busy, done/valid_out handshake of the companion shift_add_mult.
// Works on unsigned magnitudes and applies the sign afterwards, so signed
// division truncates toward zero. WIDTH must be a multiple of PARALLEL_OPS.
module shift_sub_divider
  import shift_sub_div_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int PARALLEL_OPS = 4,
  parameter int SIGNED       = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             signed_mode,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             valid_out,
  output logic             done,
  output logic             busy
);

  localparam int NUM_CYCLES = num_cycles(WIDTH, PARALLEL_OPS);
  localparam int CNT_W      = (NUM_CYCLES > 1) ? $clog2(NUM_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NUM_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t                  state;
  logic [CNT_W-1:0]        count;
  // Dividend magnitude; shifts out MSB-first while quotient bits shift in.
  logic [WIDTH-1:0]        dvd_sr;
  logic [WIDTH-1:0]        dvs_mag;
  logic [WIDTH-1:0]        rem_part;
  logic                    eff_signed_q;
  logic                    quot_neg;
  logic                    rem_neg;

  logic                    eff_signed;
  logic                    accept;
  logic                    divisor_zero;
  logic [WIDTH-1:0]        dividend_mag;
  logic [WIDTH-1:0]        divisor_mag;
  logic [WIDTH-1:0]        rem_next;
  logic [PARALLEL_OPS-1:0] quot_bits;
  logic [WIDTH-1:0]        quot_shifted;
  logic [WIDTH-1:0]        quot_final;
  logic [WIDTH-1:0]        rem_final;

  // Request qualification and operand magnitudes at acceptance.
  always_comb begin
    eff_signed   = (SIGNED != 0) && signed_mode;
    accept       = start && valid_in && ((state == IDLE) || (state == DONE));
    divisor_zero = (divisor == '0);
    dividend_mag = WIDTH'(abs_value(MAX_WIDTH'(dividend), eff_signed && dividend[WIDTH-1]));
    divisor_mag  = WIDTH'(abs_value(MAX_WIDTH'(divisor), eff_signed && divisor[WIDTH-1]));
  end

  div_step_chain #(
    .WIDTH       (WIDTH),
    .PARALLEL_OPS(PARALLEL_OPS)
  ) u_step_chain (
    .rem_in       (rem_part),
    .dividend_bits(dvd_sr[WIDTH-1 -: PARALLEL_OPS]),
    .divisor      (dvs_mag),
    .rem_out      (rem_next),
    .quotient_bits(quot_bits)
  );

  // Next operand/quotient shift value and sign-corrected final results.
  always_comb begin
    quot_shifted = (dvd_sr << PARALLEL_OPS) | WIDTH'(quot_bits);
    quot_final   = WIDTH'(cond_negate(MAX_WIDTH'(quot_shifted), eff_signed_q && quot_neg));
    rem_final    = WIDTH'(cond_negate(MAX_WIDTH'(rem_next), eff_signed_q && rem_neg));
  end

  // FSM, iteration datapath and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      dvd_sr       <= '0;
      dvs_mag      <= '0;
      rem_part     <= '0;
      eff_signed_q <= 1'b0;
      quot_neg     <= 1'b0;
      rem_neg      <= 1'b0;
      quotient     <= '0;
      remainder    <= '0;
      div_by_zero  <= 1'b0;
      valid_out    <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments for all state so every register
      // samples the values from before this edge, independent of order.
      // Handshake outputs trail the state by one cycle, which places busy
      // over the CALC steps and the done pulse after the DONE state.
      busy      <= (state == CALC);
      done      <= (state == DONE);
      valid_out <= (state == DONE);

      case (state)
        CALC: begin
          dvd_sr   <= quot_shifted;
          rem_part <= rem_next;
          count    <= count - CNT_ONE;
          if (count == '0) begin
            state     <= DONE;
            quotient  <= quot_final;
            remainder <= rem_final;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // A new request overrides the DONE->IDLE return; CALC never accepts.
      if (accept) begin
        dvd_sr       <= dividend_mag;
        dvs_mag      <= divisor_mag;
        rem_part     <= '0;
        count        <= CNT_LOAD;
        eff_signed_q <= eff_signed;
        quot_neg     <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
        rem_neg      <= dividend[WIDTH-1];
        div_by_zero  <= divisor_zero;
        if (divisor_zero) begin
          // Skip the iterations; the raw dividend is reported as remainder.
          state     <= DONE;
          quotient  <= '1;
          remainder <= dividend;
        end else begin
          state <= CALC;
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed and random checks of shift_sub_divider. Three instances with
// PARALLEL_OPS = 4, 1 and 8 share one stimulus stream.
module tb_shift_sub_divider;

  localparam int WINDOW = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        valid_in;
  logic        signed_mode;
  logic [15:0] dividend;
  logic [15:0] divisor;

  logic [15:0] quotient    [3];
  logic [15:0] remainder   [3];
  logic        div_by_zero [3];
  logic        valid_out   [3];
  logic        done        [3];
  logic        busy        [3];

  int n_checks = 0;
  int n_pass   = 0;
  int vo_bad   = 0;

  // Per-instance observations from the most recent run_div.
  int          busy_cnt [3];
  int          done_cnt [3];
  int          done_n   [3];
  int          done2_n  [3];
  logic [15:0] res_q    [3];
  logic [15:0] res_r    [3];
  logic        res_dz   [3];
  logic [15:0] res_q2   [3];
  logic [15:0] res_r2   [3];

  shift_sub_divider #(.WIDTH(16), .PARALLEL_OPS(4), .SIGNED(1)) dut_p4 (
    .clk(clk), .rst(rst), .start(start), .valid_in(valid_in),
    .dividend(dividend), .divisor(divisor), .signed_mode(signed_mode),
    .quotient(quotient[0]), .remainder(remainder[0]), .div_by_zero(div_by_zero[0]),
    .valid_out(valid_out[0]), .done(done[0]), .busy(busy[0]));

  shift_sub_divider #(.WIDTH(16), .PARALLEL_OPS(1), .SIGNED(1)) dut_p1 (
    .clk(clk), .rst(rst), .start(start), .valid_in(valid_in),
    .dividend(dividend), .divisor(divisor), .signed_mode(signed_mode),
    .quotient(quotient[1]), .remainder(remainder[1]), .div_by_zero(div_by_zero[1]),
    .valid_out(valid_out[1]), .done(done[1]), .busy(busy[1]));

  shift_sub_divider #(.WIDTH(16), .PARALLEL_OPS(8), .SIGNED(1)) dut_p8 (
    .clk(clk), .rst(rst), .start(start), .valid_in(valid_in),
    .dividend(dividend), .divisor(divisor), .signed_mode(signed_mode),
    .quotient(quotient[2]), .remainder(remainder[2]), .div_by_zero(div_by_zero[2]),
    .valid_out(valid_out[2]), .done(done[2]), .busy(busy[2]));

  always #5 clk = ~clk;

  function automatic int ncyc(input int idx);
    case (idx)
      0:       return 4;
      1:       return 16;
      default: return 2;
    endcase
  endfunction

  function automatic int pops(input int idx);
    case (idx)
      0:       return 4;
      1:       return 1;
      default: return 8;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Issue one request, then watch WINDOW cycles. Sample n is the cycle after
  // acceptance edge k+n. Optionally raise another request at sample inj_n.
  task automatic run_div(input logic [15:0] a, input logic [15:0] b, input logic sm,
                         input int inj_n, input logic [15:0] ia, input logic [15:0] ib);
    @(negedge clk);
    dividend    = a;
    divisor     = b;
    signed_mode = sm;
    start       = 1'b1;
    valid_in    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      busy_cnt[i] = 0;
      done_cnt[i] = 0;
      done_n[i]   = -1;
      done2_n[i]  = -1;
    end
    for (int n = 0; n < WINDOW; n++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (busy[i] === 1'b1) busy_cnt[i]++;
        if (valid_out[i] !== done[i]) vo_bad++;
        if (done[i] === 1'b1) begin
          if (done_cnt[i] == 0) begin
            done_n[i] = n;
            res_q[i]  = quotient[i];
            res_r[i]  = remainder[i];
            res_dz[i] = div_by_zero[i];
          end else if (done_cnt[i] == 1) begin
            done2_n[i] = n;
            res_q2[i]  = quotient[i];
            res_r2[i]  = remainder[i];
          end
          done_cnt[i]++;
        end
      end
      start    = (n == inj_n);
      valid_in = start;
      if (n == inj_n) begin
        dividend = ia;
        divisor  = ib;
      end
    end
  endtask

  // One divide with a single expected result for all three instances.
  task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic sm, input logic [15:0] eq, input logic [15:0] er,
                          input logic edz);
    run_div(a, b, sm, -1, '0, '0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_q_p%0d", tag, pops(i)), res_q[i], eq);
      check($sformatf("%s_r_p%0d", tag, pops(i)), res_r[i], er);
      check($sformatf("%s_dz_p%0d", tag, pops(i)), res_dz[i], edz);
      check($sformatf("%s_ndone_p%0d", tag, pops(i)), done_cnt[i], 1);
      check($sformatf("%s_busy_p%0d", tag, pops(i)), busy_cnt[i], edz ? 0 : ncyc(i));
      check($sformatf("%s_lat_p%0d", tag, pops(i)), done_n[i], edz ? 1 : ncyc(i) + 1);
    end
  endtask

  initial begin
    logic [15:0]        ra, rb;
    logic signed [15:0] sa, sb;
    logic [15:0]        eq, er;
    int                 seen;

    rst         = 1'b1;
    start       = 1'b0;
    valid_in    = 1'b0;
    signed_mode = 1'b0;
    dividend    = '0;
    divisor     = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_outs_p%0d", pops(i)),
            {quotient[i], remainder[i]}, 32'h0);
      check($sformatf("reset_flags_p%0d", pops(i)),
            {div_by_zero[i], valid_out[i], done[i], busy[i]}, 32'h0);
    end
    rst = 1'b0;
    @(negedge clk);

    directed("u100_7",   16'd100,  16'd7,    1'b0, 16'd14,   16'd2,    1'b0);
    directed("s-7_2",    16'hFFF9, 16'd2,    1'b1, 16'hFFFD, 16'hFFFF, 1'b0);
    directed("s7_-2",    16'd7,    16'hFFFE, 1'b1, 16'hFFFD, 16'd1,    1'b0);
    directed("uFFF9_2",  16'hFFF9, 16'd2,    1'b0, 16'h7FFC, 16'd1,    1'b0);
    directed("s_ovf",    16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0);
    directed("uFFFF_1",  16'hFFFF, 16'd1,    1'b0, 16'hFFFF, 16'h0000, 1'b0);
    directed("div0",     16'd1234, 16'd0,    1'b0, 16'hFFFF, 16'd1234, 1'b1);
    directed("dz_clear", 16'd100,  16'd7,    1'b0, 16'd14,   16'd2,    1'b0);

    // Request during CALC is dropped; only the original result completes.
    run_div(16'd100, 16'd7, 1'b0, 1, 16'd50, 16'd5);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("ign_q_p%0d", pops(i)), res_q[i], 16'd14);
      check($sformatf("ign_r_p%0d", pops(i)), res_r[i], 16'd2);
      check($sformatf("ign_ndone_p%0d", pops(i)), done_cnt[i], 1);
    end

    // Request in the DONE cycle of the P=4 instance: 1000/9 = 111 rem 1.
    run_div(16'd100, 16'd7, 1'b0, 4, 16'd1000, 16'd9);
    check("b2b_q1",    res_q[0],    16'd14);
    check("b2b_r1",    res_r[0],    16'd2);
    check("b2b_lat1",  done_n[0],   5);
    check("b2b_q2",    res_q2[0],   16'd111);
    check("b2b_r2",    res_r2[0],   16'd1);
    check("b2b_lat2",  done2_n[0],  10);
    check("b2b_busy",  busy_cnt[0], 8);
    check("b2b_ndone", done_cnt[0], 2);

    // Reset in the middle of CALC: everything clears and no done follows.
    @(negedge clk);
    dividend    = 16'd100;
    divisor     = 16'd7;
    signed_mode = 1'b0;
    start       = 1'b1;
    valid_in    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    valid_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("midrst_outs_p%0d", pops(i)), {quotient[i], remainder[i]}, 32'h0);
      check($sformatf("midrst_flags_p%0d", pops(i)),
            {div_by_zero[i], valid_out[i], done[i], busy[i]}, 32'h0);
    end
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (WINDOW) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (done[i] === 1'b1 || busy[i] === 1'b1) seen++;
    end
    check("midrst_no_done", seen, 0);

    // Random operands against the language's / and % operators.
    for (int mode = 0; mode < 2; mode++) begin
      for (int it = 0; it < 200; it++) begin
        ra = 16'($urandom);
        rb = (it % 3 == 0) ? 16'($urandom_range(1, 15)) : 16'($urandom);
        if (rb == 16'd0) rb = 16'd3;
        if (mode == 1 && ra == 16'h8000 && rb == 16'hFFFF) rb = 16'd5;
        if (mode == 0) begin
          eq = ra / rb;
          er = ra % rb;
        end else begin
          sa = ra;
          sb = rb;
          eq = sa / sb;
          er = sa % sb;
        end
        run_div(ra, rb, mode[0], -1, '0, '0);
        for (int i = 0; i < 3; i++) begin
          check($sformatf("rnd_m%0d_%0d_q_p%0d(%0h/%0h)", mode, it, pops(i), ra, rb), res_q[i], eq);
          check($sformatf("rnd_m%0d_%0d_r_p%0d(%0h/%0h)", mode, it, pops(i), ra, rb), res_r[i], er);
          check($sformatf("rnd_m%0d_%0d_busy_p%0d", mode, it, pops(i)), busy_cnt[i], ncyc(i));
          check($sformatf("rnd_m%0d_%0d_lat_p%0d", mode, it, pops(i)), done_n[i], ncyc(i) + 1);
        end
      end
    end

    check("valid_out_eq_done", vo_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound so the bench can never hang.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded its time bound");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shift_sub_divider.md
Name: shift_sub_divider

Overview:
Iterative restoring shift-subtract divider. It is the inverse companion of the team's parametric shift_add_mult and uses the same start/valid_in/busy/done/valid_out handshake. Each CALC cycle retires PARALLEL_OPS quotient bits, so a divide takes WIDTH/PARALLEL_OPS cycles. It sits beside the multiplier in the arithmetic unit and supports signed and unsigned modes. Division truncates toward zero.

Parameters:
WIDTH, 16, operand, quotient and remainder width; must be a multiple of PARALLEL_OPS.
PARALLEL_OPS, 4, quotient bits resolved per CALC cycle (1, 2, 4 or 8).
SIGNED, 1, 1 enables the signed_mode input; 0 forces unsigned regardless of signed_mode.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
start  in  1  request a divide; qualified with valid_in
valid_in  in  1  operands valid
dividend  in  WIDTH  numerator
divisor  in  WIDTH  denominator
signed_mode  in  1  1 = two's-complement operation (only when SIGNED=1)
quotient  out  WIDTH  registered quotient
remainder  out  WIDTH  registered remainder
div_by_zero  out  1  set with done when divisor was 0
valid_out  out  1  one-cycle pulse, same cycle as done
done  out  1  one-cycle completion pulse
busy  out  1  high during CALC

Behaviour:
- Reset (asynchronous): state=IDLE. quotient, remainder, div_by_zero, valid_out, done and busy are all 0.
- States:
  - IDLE: accept a request.
  - CALC: NUM_CYCLES = WIDTH/PARALLEL_OPS cycles.
  - DONE: exactly 1 cycle, then IDLE.
- Acceptance: on a posedge where start&valid_in=1 and state is IDLE or DONE.
  - Latch |dividend| and |divisor|, eff_signed = SIGNED & signed_mode, q_neg = sign(dividend) XOR sign(divisor), r_neg = sign(dividend).
  - Zero the partial remainder and load the iteration counter with NUM_CYCLES-1.
- Requests while in CALC are ignored. There is no queue and busy stays asserted.
- CALC step: per cycle, PARALLEL_OPS chained restoring steps run MSB-first. Each step:
  - Shift the partial remainder left by 1 and bring in the next dividend bit.
  - Compute trial = rem − divisor in WIDTH+1 bits.
  - If trial is non-negative: rem = trial and the quotient bit is 1. Otherwise rem is kept and the quotient bit is 0.
- Counter: when it reaches 0 in CALC, go to DONE.
- Result registration: quotient and remainder are registered on that same edge, with sign fixup applied when eff_signed:
  - quotient negated if q_neg.
  - remainder negated if r_neg.
- Latency: acceptance at edge k gives busy=1 over k+1..k+NUM_CYCLES, and done=valid_out=1 (busy=0) in the cycle following edge k+NUM_CYCLES+1.
- Outputs: quotient and remainder hold their value until the next completion.
- Divide by zero (divisor==0 at acceptance): skip CALC and go directly to DONE (done one cycle after acceptance).
  - quotient={WIDTH{1'b1}}, remainder=dividend (raw), div_by_zero=1.
  - div_by_zero clears at the next acceptance.
- Signed overflow (most-negative / −1): falls out of magnitude arithmetic and gives quotient=most-negative, remainder=0, div_by_zero=0. No special case is needed.
- Magnitude: |most-negative| is treated as an unsigned WIDTH-bit value, and all internal magnitudes are unsigned.
- Reset asserted mid-CALC: immediate return to IDLE, all outputs 0, no done pulse.
- Back-to-back: a new start accepted in the DONE cycle enters CALC on the next edge. done still pulses for the old result.

Decomposition:
- Package shift_sub_div_pkg holds:
  - state enum {IDLE, CALC, DONE};
  - function num_cycles(WIDTH, PARALLEL_OPS);
  - abs/negate helper functions.
- One sub-module: div_step_chain. It is a combinational chain of PARALLEL_OPS restoring steps.
  - Inputs: rem, dividend bits, divisor.
  - Outputs: new rem, PARALLEL_OPS quotient bits.
- The top level holds the FSM, counter, operand shift register and sign fixup.

Test Plan:
- Unsigned 100/7 (WIDTH=16, PARALLEL_OPS=4) -> quotient=14, remainder=2, busy for exactly 4 cycles, done/valid_out one-cycle pulse 5 cycles after acceptance.
- Signed truncation:
  - −7/2 -> quotient=0xFFFD (−3), remainder=0xFFFF (−1).
  - 7/−2 -> quotient=0xFFFD, remainder=1.
  - Same operands with signed_mode=0 -> 0xFFF9/2 = 0x7FFC, remainder 1.
- Signed 0x8000/0xFFFF -> quotient=0x8000, remainder=0, div_by_zero=0.
  - Unsigned 0xFFFF/0x0001 -> quotient=0xFFFF, remainder=0.
- Divide by zero 1234/0 -> quotient=0xFFFF, remainder=1234, div_by_zero=1, done exactly one cycle after acceptance, busy never asserted.
  - Next valid divide clears div_by_zero.
- Control:
  - start during CALC is ignored; the original result completes.
  - rst pulse mid-CALC -> all outputs 0, no done.
  - start in the DONE cycle -> second result correct after 4 further busy cycles.
- Random: 200 random pairs with nonzero divisor in each mode, checked against the Verilog / and % operators (signed casts for signed mode).
  - Repeat with PARALLEL_OPS=1 and 8: busy cycles equal 16 and 2 respectively.
